// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use, taken branch, memory busywait and multi-cycle MUL/DIV.
// Optional build macro STALL_PERF_COUNTER_EN adds the 32-bit STALL_COUNT performance counter.
module hazard_stall_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USES_RS1,
    input  logic        ID_USES_RS2,
    input  logic [4:0]  EX_RD,
    input  logic        EX_MEM_READ,
    input  logic        EX_BRANCH_TAKEN,
    input  logic        EX_MULDIV_START,
    input  logic        MULDIV_DONE,
    input  logic        IMEM_BUSYWAIT,
    input  logic        DMEM_BUSYWAIT,
    output logic        PC_HOLD,
    output logic        IF_ID_HOLD,
    output logic        ID_EX_HOLD,
    output logic        EX_MEM_HOLD,
    output logic        MEM_WB_HOLD,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH,
    output logic        EX_MEM_FLUSH,
    output logic        MULDIV_TIMEOUT
`ifdef STALL_PERF_COUNTER_EN
    ,
    output logic [31:0] STALL_COUNT
`endif
);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MULDIV_WAIT = 2'd1,
        TIMEOUT     = 2'd2
    } state_t;

    localparam logic [5:0] WAIT_LIMIT = 6'd63;

    state_t     state, state_nxt;
    logic [5:0] wait_cnt, wait_cnt_nxt;
    logic       timeout_flag, timeout_flag_nxt;
    logic       busywait;
    logic       load_use;

    assign busywait = IMEM_BUSYWAIT | DMEM_BUSYWAIT;

    // A load into x0 never creates a dependency.
    assign load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                      ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                       (ID_USES_RS2 && (ID_RS2 == EX_RD)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= RUN;
            wait_cnt     <= 6'd0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            timeout_flag <= timeout_flag_nxt;
        end
    end

    // NOTE: every output and next-state term is given a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_nxt        = state;
        wait_cnt_nxt     = wait_cnt;
        timeout_flag_nxt = timeout_flag;
        PC_HOLD          = 1'b0;
        IF_ID_HOLD       = 1'b0;
        ID_EX_HOLD       = 1'b0;
        EX_MEM_HOLD      = 1'b0;
        MEM_WB_HOLD      = 1'b0;
        IF_ID_FLUSH      = 1'b0;
        ID_EX_FLUSH      = 1'b0;
        EX_MEM_FLUSH     = 1'b0;

        if (!RESET || busywait) begin
            // Whole pipeline frozen; FSM and counter do not advance.
            PC_HOLD     = 1'b1;
            IF_ID_HOLD  = 1'b1;
            ID_EX_HOLD  = 1'b1;
            EX_MEM_HOLD = 1'b1;
            MEM_WB_HOLD = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (EX_BRANCH_TAKEN) begin
                        IF_ID_FLUSH = 1'b1;
                        ID_EX_FLUSH = 1'b1;
                    end else begin
                        if (load_use) begin
                            PC_HOLD     = 1'b1;
                            IF_ID_HOLD  = 1'b1;
                            ID_EX_FLUSH = 1'b1;
                        end
                        if (EX_MULDIV_START) begin
                            state_nxt    = MULDIV_WAIT;
                            wait_cnt_nxt = 6'd0;
                        end
                    end
                end

                MULDIV_WAIT: begin
                    if (MULDIV_DONE) begin
                        state_nxt = RUN;
                    end else begin
                        PC_HOLD      = 1'b1;
                        IF_ID_HOLD   = 1'b1;
                        ID_EX_HOLD   = 1'b1;
                        EX_MEM_FLUSH = 1'b1;
                        if (wait_cnt == WAIT_LIMIT) begin
                            state_nxt        = TIMEOUT;
                            timeout_flag_nxt = 1'b1;
                        end else begin
                            wait_cnt_nxt = wait_cnt + 6'd1;
                        end
                    end
                end

                TIMEOUT: begin
                    ID_EX_FLUSH  = 1'b1;
                    EX_MEM_FLUSH = 1'b1;
                    state_nxt    = RUN;
                end

                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign MULDIV_TIMEOUT = timeout_flag;

`ifdef STALL_PERF_COUNTER_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            STALL_COUNT <= 32'd0;
        end else if (PC_HOLD) begin
            STALL_COUNT <= STALL_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the stall rules.
module tb_hazard_stall_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  ID_RS1, ID_RS2, EX_RD;
    logic        ID_USES_RS1, ID_USES_RS2, EX_MEM_READ;
    logic        EX_BRANCH_TAKEN, EX_MULDIV_START, MULDIV_DONE;
    logic        IMEM_BUSYWAIT, DMEM_BUSYWAIT;
    logic        PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD;
    logic        IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MULDIV_TIMEOUT;
    logic [31:0] STALL_COUNT;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model state: is a MUL/DIV outstanding, how many wait cycles
    // it has consumed, is this the one-cycle timeout recovery, sticky error.
    bit          m_busy;
    int          m_elapsed;
    bit          m_timeout_cycle;
    bit          m_sticky;
    logic [31:0] m_stalls;

    hazard_stall_controller dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .ID_RS1          (ID_RS1),
        .ID_RS2          (ID_RS2),
        .ID_USES_RS1     (ID_USES_RS1),
        .ID_USES_RS2     (ID_USES_RS2),
        .EX_RD           (EX_RD),
        .EX_MEM_READ     (EX_MEM_READ),
        .EX_BRANCH_TAKEN (EX_BRANCH_TAKEN),
        .EX_MULDIV_START (EX_MULDIV_START),
        .MULDIV_DONE     (MULDIV_DONE),
        .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
        .DMEM_BUSYWAIT   (DMEM_BUSYWAIT),
        .PC_HOLD         (PC_HOLD),
        .IF_ID_HOLD      (IF_ID_HOLD),
        .ID_EX_HOLD      (ID_EX_HOLD),
        .EX_MEM_HOLD     (EX_MEM_HOLD),
        .MEM_WB_HOLD     (MEM_WB_HOLD),
        .IF_ID_FLUSH     (IF_ID_FLUSH),
        .ID_EX_FLUSH     (ID_EX_FLUSH),
        .EX_MEM_FLUSH    (EX_MEM_FLUSH),
        .MULDIV_TIMEOUT  (MULDIV_TIMEOUT)
`ifdef STALL_PERF_COUNTER_EN
        ,
        .STALL_COUNT     (STALL_COUNT)
`endif
    );

`ifndef STALL_PERF_COUNTER_EN
    assign STALL_COUNT = 32'd0;
`endif

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_ctrl();
        return {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD,
                IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH};
    endfunction

    // Expected {5 holds PC..MEM_WB, 3 flushes IF_ID..EX_MEM} from the stall rules.
    function automatic logic [7:0] expected_ctrl();
        bit bw;
        bit load_use;
        bw       = IMEM_BUSYWAIT || DMEM_BUSYWAIT;
        load_use = EX_MEM_READ && (EX_RD != 0) &&
                   ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
        if (!RESET || bw)    return 8'b11111_000;
        if (m_timeout_cycle) return 8'b00000_011;
        if (m_busy)          return MULDIV_DONE ? 8'b00000_000 : 8'b11100_001;
        if (EX_BRANCH_TAKEN) return 8'b00000_110;
        if (load_use)        return 8'b11000_010;
        return 8'b00000_000;
    endfunction

    task automatic model_reset();
        m_busy          = 1'b0;
        m_elapsed       = 0;
        m_timeout_cycle = 1'b0;
        m_sticky        = 1'b0;
        m_stalls        = 32'd0;
    endtask

    task automatic model_step(input logic [7:0] exp);
        if (exp[7]) m_stalls = m_stalls + 32'd1;
        if (IMEM_BUSYWAIT || DMEM_BUSYWAIT) return;
        if (m_timeout_cycle) begin
            m_timeout_cycle = 1'b0;
        end else if (m_busy) begin
            if (MULDIV_DONE) begin
                m_busy = 1'b0;
            end else begin
                m_elapsed++;
                if (m_elapsed == 64) begin
                    m_busy          = 1'b0;
                    m_timeout_cycle = 1'b1;
                    m_sticky        = 1'b1;
                end
            end
        end else if (!EX_BRANCH_TAKEN && EX_MULDIV_START) begin
            m_busy    = 1'b1;
            m_elapsed = 0;
        end
    endtask

    // Inputs are set just after a rising edge; outputs checked mid-cycle.
    task automatic cycle(input string tag);
        logic [7:0] exp;
        #2;
        if (!RESET) model_reset();
        exp = expected_ctrl();
        check({tag, ":ctrl"}, {24'd0, dut_ctrl()}, {24'd0, exp});
        check({tag, ":timeout"}, {31'd0, MULDIV_TIMEOUT}, {31'd0, m_sticky});
`ifdef STALL_PERF_COUNTER_EN
        check({tag, ":stall_count"}, STALL_COUNT, m_stalls);
`endif
        @(posedge CLK);
        if (RESET) model_step(exp);
        #1;
    endtask

    task automatic idle();
        RESET           = 1'b1;
        ID_RS1          = 5'd0;
        ID_RS2          = 5'd0;
        EX_RD           = 5'd0;
        ID_USES_RS1     = 1'b0;
        ID_USES_RS2     = 1'b0;
        EX_MEM_READ     = 1'b0;
        EX_BRANCH_TAKEN = 1'b0;
        EX_MULDIV_START = 1'b0;
        MULDIV_DONE     = 1'b0;
        IMEM_BUSYWAIT   = 1'b0;
        DMEM_BUSYWAIT   = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        EX_MEM_READ = 1'b1;
        EX_RD       = rd;
        ID_RS2      = rd;
        ID_USES_RS2 = 1'b1;
    endtask

    task automatic start_muldiv(input string tag);
        idle();
        EX_MULDIV_START = 1'b1;
        cycle(tag);
        idle();
    endtask

    initial begin
        model_reset();
        idle();
        RESET = 1'b0;
        #1;
        check("reset_hold", {24'd0, dut_ctrl()}, 32'h0000_00F8);
        check("reset_timeout", {31'd0, MULDIV_TIMEOUT}, 32'd0);
        cycle("reset");
        EX_BRANCH_TAKEN = 1'b1;
        set_load_use(5'd7);
        cycle("reset_with_inputs");
        idle();
        cycle("first_run");

        // Load-use on RS2, one cycle only; then the x0 case.
        set_load_use(5'd5);
        #1;
        check("lu_pc_hold", {31'd0, PC_HOLD}, 32'd1);
        check("lu_id_ex_flush", {31'd0, ID_EX_FLUSH}, 32'd1);
        cycle("lu");
        idle();
        cycle("lu_after");
        set_load_use(5'd0);
        cycle("lu_x0");

        // Branch wins over load-use.
        idle();
        set_load_use(5'd9);
        EX_BRANCH_TAKEN = 1'b1;
        #1;
        check("br_lu_pc_hold", {31'd0, PC_HOLD}, 32'd0);
        check("br_lu_if_id_flush", {31'd0, IF_ID_FLUSH}, 32'd1);
        cycle("br_lu");
        EX_MULDIV_START = 1'b1;
        cycle("br_start");
        idle();
        cycle("br_start_after");

        // MUL with DONE after 10 wait cycles.
        start_muldiv("mul_start");
        for (int i = 0; i < 10; i++) cycle("mul_wait");
        MULDIV_DONE = 1'b1;
        #1;
        check("mul_done_ctrl", {24'd0, dut_ctrl()}, 32'd0);
        cycle("mul_done");
        idle();
        cycle("mul_run");

        // Busywait coinciding with DONE: frozen, DONE accepted afterwards.
        start_muldiv("bw_start");
        cycle("bw_wait");
        for (int i = 0; i < 3; i++) begin
            DMEM_BUSYWAIT = 1'b1;
            MULDIV_DONE   = 1'b1;
            cycle("bw_done_frozen");
        end
        DMEM_BUSYWAIT = 1'b0;
        cycle("bw_done_accept");
        idle();
        cycle("bw_run");

        // No DONE: timeout after 64 wait cycles, flag sticky.
        start_muldiv("to_start");
        for (int i = 0; i < 64; i++) cycle("to_wait");
        #1;
        check("to_flush", {30'd0, ID_EX_FLUSH, EX_MEM_FLUSH}, 32'd3);
        check("to_flag", {31'd0, MULDIV_TIMEOUT}, 32'd1);
        cycle("to_state");
        for (int i = 0; i < 3; i++) cycle("to_back_run");
        start_muldiv("to_restart");
        MULDIV_DONE = 1'b1;
        cycle("to_restart_done");
        idle();

        // Reset in the middle of a wait; late DONE ignored.
        start_muldiv("rst_mid_start");
        for (int i = 0; i < 5; i++) cycle("rst_mid_wait");
        RESET = 1'b0;
        #1;
        check("rst_mid_hold", {24'd0, dut_ctrl()}, 32'h0000_00F8);
        check("rst_mid_timeout", {31'd0, MULDIV_TIMEOUT}, 32'd0);
`ifdef STALL_PERF_COUNTER_EN
        check("rst_mid_stall_count", STALL_COUNT, 32'd0);
`endif
        cycle("rst_mid_reset");
        idle();
        MULDIV_DONE = 1'b1;
        cycle("rst_late_done");
        cycle("rst_late_done2");
        idle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            RESET           = ($urandom_range(0, 299) != 0);
            EX_BRANCH_TAKEN = ($urandom_range(0, 9) == 0);
            EX_MULDIV_START = ($urandom_range(0, 7) == 0);
            MULDIV_DONE     = ($urandom_range(0, 5) == 0);
            IMEM_BUSYWAIT   = ($urandom_range(0, 11) == 0);
            DMEM_BUSYWAIT   = ($urandom_range(0, 11) == 0);
            EX_MEM_READ     = ($urandom_range(0, 1) == 1);
            ID_USES_RS1     = ($urandom_range(0, 1) == 1);
            ID_USES_RS2     = ($urandom_range(0, 1) == 1);
            EX_RD           = 5'($urandom_range(0, 3));
            ID_RS1          = 5'($urandom_range(0, 3));
            ID_RS2          = 5'($urandom_range(0, 3));
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
